// File: rtl/count_cmd_sequencer.sv
// count_cmd_sequencer
//   Command sequencer for a loadable up/down counter (range MIN_VAL..MAX_VAL).
//   Commands (LOAD/UP/DOWN/HOLD) arrive on a valid/ready handshake. The
//   sequencer drives the counter's active-low load, data_in and up_down
//   inputs every cycle. It tracks a shadow of the counter value so the
//   counter can be reloaded with its own value whenever no command runs.
// Ports
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   cmd_valid/ready  : command handshake (ready only while idle)
//   cmd_op           : 00 LOAD, 01 UP, 10 DOWN, 11 HOLD
//   cmd_data         : LOAD value
//   cmd_steps        : cycle count for UP/DOWN/HOLD (0 behaves as 1)
//   load, data_in,
//   up_down          : registered counter controls
//   shadow_count     : expected counter value after the current edge
//   done, cmd_err    : one-cycle completion / rejection pulses
module count_cmd_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 2,
  parameter int MAX_VAL = 10,
  parameter int STEP_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              load,
  output logic [WIDTH-1:0]  data_in,
  output logic              up_down,
  output logic [WIDTH-1:0]  shadow_count,
  output logic              done,
  output logic              cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  localparam logic [WIDTH:0]    MIN_X = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]    MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0]  MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]  MAX_W = WIDTH'(MAX_VAL);
  localparam logic [STEP_W-1:0] ONE_S = STEP_W'(1);

  // Wrap arithmetic is done one bit wider so MAX_VAL+1 and 0-1 cannot alias.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = {1'b0, v} + (WIDTH+1)'(1);
    if (s > MAX_X) return MIN_W;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = {1'b0, v} - (WIDTH+1)'(1);
    if ((s < MIN_X) || (s > MAX_X)) return MAX_W;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic in_range(input logic [WIDTH-1:0] v);
    return ({1'b0, v} >= MIN_X) && ({1'b0, v} <= MAX_X);
  endfunction

  state_t              state, state_n;
  logic [STEP_W-1:0]   steps_left, steps_n, steps_eff;
  logic [WIDTH-1:0]    shadow_n, data_n;
  logic                load_n, ud_n, ready_n, done_n, err_n;

  assign steps_eff = (cmd_steps == '0) ? ONE_S : cmd_steps;

  always_comb begin
    state_n  = state;
    steps_n  = steps_left;
    shadow_n = shadow_count;
    load_n   = load;
    data_n   = data_in;
    ud_n     = up_down;
    ready_n  = cmd_ready;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      S_IDLE: begin
        // Idle: reload the counter with its own value so it stays put.
        load_n  = 1'b0;
        data_n  = shadow_count;
        ready_n = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              if (in_range(cmd_data)) begin
                state_n = S_LOAD;
                data_n  = cmd_data;
                ready_n = 1'b0;
              end else begin
                err_n = 1'b1;
              end
            end
            2'b01, 2'b10: begin
              state_n = S_RUN;
              steps_n = steps_eff;
              load_n  = 1'b1;
              ud_n    = (cmd_op == 2'b01);
              ready_n = 1'b0;
            end
            default: begin
              state_n = S_HOLD;
              steps_n = steps_eff;
              ready_n = 1'b0;
            end
          endcase
        end
      end
      S_LOAD: begin
        // data_in still carries the accepted load value this cycle.
        shadow_n = data_in;
        state_n  = S_IDLE;
        done_n   = 1'b1;
        ready_n  = 1'b1;
        load_n   = 1'b0;
      end
      S_RUN: begin
        shadow_n = up_down ? wrap_inc(shadow_count) : wrap_dec(shadow_count);
        if (steps_left == ONE_S) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          ready_n = 1'b1;
          load_n  = 1'b0;
          data_n  = shadow_n;
        end else begin
          steps_n = steps_left - ONE_S;
        end
      end
      default: begin
        load_n = 1'b0;
        data_n = shadow_count;
        if (steps_left == ONE_S) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          ready_n = 1'b1;
        end else begin
          steps_n = steps_left - ONE_S;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      steps_left   <= '0;
      shadow_count <= MIN_W;
      load         <= 1'b0;
      data_in      <= MIN_W;
      up_down      <= 1'b1;
      cmd_ready    <= 1'b1;
      done         <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      state        <= state_n;
      steps_left   <= steps_n;
      shadow_count <= shadow_n;
      load         <= load_n;
      data_in      <= data_n;
      up_down      <= ud_n;
      cmd_ready    <= ready_n;
      done         <= done_n;
      cmd_err      <= err_n;
    end
  end

endmodule

// File: tb/tb_count_cmd_sequencer.sv
// Directed testbench for count_cmd_sequencer with a behavioural model of the
// 2..10 up/down counter hanging off the sequencer outputs.
module tb_count_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic [7:0] cmd_steps = 8'd0;
  logic       load;
  logic [3:0] data_in;
  logic       up_down;
  logic [3:0] shadow_count;
  logic       done;
  logic       cmd_err;

  int checks = 0;
  int passed = 0;

  count_cmd_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
    .load(load), .data_in(data_in), .up_down(up_down),
    .shadow_count(shadow_count), .done(done), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  // Counter being sequenced: active-low load, otherwise count with wrap.
  logic [3:0] ctr;
  always @(posedge clock) begin
    if (!load) ctr <= data_in;
    else if (up_down) ctr <= (ctr >= 4'd10) ? 4'd2 : ctr + 4'd1;
    else ctr <= (ctr <= 4'd2) ? 4'd10 : ctr - 4'd1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [7:0] s);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_steps = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (load !== 1'b0) $display("FAIL rst_load got %0b want 0", load); else passed++;
    checks++; if (data_in !== 4'd2) $display("FAIL rst_data_in got %0d want 2", data_in); else passed++;
    checks++; if (up_down !== 1'b1) $display("FAIL rst_up_down got %0b want 1", up_down); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", cmd_ready); else passed++;
    checks++; if (shadow_count !== 4'd2) $display("FAIL rst_shadow got %0d want 2", shadow_count); else passed++;
    checks++; if (done !== 1'b0 || cmd_err !== 1'b0) $display("FAIL rst_pulses got done=%0b err=%0b want 0/0", done, cmd_err); else passed++;
    reset = 1'b0;
    tick();
    checks++; if (ctr !== 4'd2) $display("FAIL rst_counter got %0d want 2", ctr); else passed++;
  endtask

  task automatic test_load_up_wrap();
    logic [3:0] exp_seq [7] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd2, 4'd3};
    issue(2'b00, 4'd5, 8'd0);
    checks++; if (load !== 1'b0 || data_in !== 4'd5 || cmd_ready !== 1'b0)
      $display("FAIL load_drive got load=%0b data_in=%0d ready=%0b want 0/5/0", load, data_in, cmd_ready); else passed++;
    tick();
    checks++; if (shadow_count !== 4'd5 || done !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL load_done got shadow=%0d done=%0b ready=%0b want 5/1/1", shadow_count, done, cmd_ready); else passed++;
    checks++; if (ctr !== 4'd5) $display("FAIL load_counter got %0d want 5", ctr); else passed++;
    issue(2'b01, 4'd0, 8'd7);
    checks++; if (load !== 1'b1 || up_down !== 1'b1 || shadow_count !== 4'd5 || done !== 1'b0)
      $display("FAIL up_start got load=%0b ud=%0b shadow=%0d done=%0b want 1/1/5/0", load, up_down, shadow_count, done); else passed++;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (shadow_count !== exp_seq[i]) $display("FAIL up_shadow[%0d] got %0d want %0d", i, shadow_count, exp_seq[i]); else passed++;
      checks++; if (ctr !== exp_seq[i]) $display("FAIL up_counter[%0d] got %0d want %0d", i, ctr, exp_seq[i]); else passed++;
      checks++; if (done !== (i == 6)) $display("FAIL up_done[%0d] got %0b want %0b", i, done, (i == 6)); else passed++;
    end
    checks++; if (load !== 1'b0 || data_in !== 4'd3) $display("FAIL up_end got load=%0b data_in=%0d want 0/3", load, data_in); else passed++;
    tick(); tick();
    checks++; if (ctr !== 4'd3 || shadow_count !== 4'd3 || done !== 1'b0)
      $display("FAIL up_idle got ctr=%0d shadow=%0d done=%0b want 3/3/0", ctr, shadow_count, done); else passed++;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_seq [3] = '{4'd2, 4'd10, 4'd9};
    issue(2'b10, 4'd0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (load !== 1'b1 || up_down !== 1'b0) $display("FAIL dn_ctrl[%0d] got load=%0b ud=%0b want 1/0", i, load, up_down); else passed++;
      tick();
      checks++; if (shadow_count !== exp_seq[i] || ctr !== exp_seq[i])
        $display("FAIL dn_value[%0d] got shadow=%0d ctr=%0d want %0d", i, shadow_count, ctr, exp_seq[i]); else passed++;
    end
    checks++; if (load !== 1'b0 || done !== 1'b1 || up_down !== 1'b0)
      $display("FAIL dn_end got load=%0b done=%0b ud=%0b want 0/1/0", load, done, up_down); else passed++;
    tick();
  endtask

  task automatic test_bad_load();
    logic [3:0] bad [2] = '{4'd11, 4'd1};
    for (int i = 0; i < 2; i++) begin
      issue(2'b00, bad[i], 8'd0);
      checks++; if (cmd_err !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b1)
        $display("FAIL bad_err[%0d] got err=%0b done=%0b ready=%0b want 1/0/1", i, cmd_err, done, cmd_ready); else passed++;
      checks++; if (load !== 1'b0 || data_in !== 4'd9 || shadow_count !== 4'd9)
        $display("FAIL bad_outs[%0d] got load=%0b data_in=%0d shadow=%0d want 0/9/9", i, load, data_in, shadow_count); else passed++;
      tick();
      checks++; if (cmd_err !== 1'b0 || done !== 1'b0 || ctr !== 4'd9 || shadow_count !== 4'd9)
        $display("FAIL bad_after[%0d] got err=%0b done=%0b ctr=%0d shadow=%0d want 0/0/9/9", i, cmd_err, done, ctr, shadow_count); else passed++;
    end
  endtask

  task automatic test_hold_and_zero();
    issue(2'b11, 4'd0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (load !== 1'b0 || data_in !== 4'd9) $display("FAIL hold_ctrl[%0d] got load=%0b data_in=%0d want 0/9", i, load, data_in); else passed++;
      tick();
      checks++; if (ctr !== 4'd9 || shadow_count !== 4'd9 || done !== (i == 3))
        $display("FAIL hold_state[%0d] got ctr=%0d shadow=%0d done=%0b want 9/9/%0b", i, ctr, shadow_count, done, (i == 3)); else passed++;
    end
    issue(2'b01, 4'd0, 8'd0);
    tick();
    checks++; if (shadow_count !== 4'd10 || done !== 1'b1 || ctr !== 4'd10)
      $display("FAIL zero_steps got shadow=%0d done=%0b ctr=%0d want 10/1/10", shadow_count, done, ctr); else passed++;
    tick();
    checks++; if (shadow_count !== 4'd10 || done !== 1'b0) $display("FAIL zero_after got shadow=%0d done=%0b want 10/0", shadow_count, done); else passed++;
  endtask

  task automatic test_reset_mid();
    issue(2'b01, 4'd0, 8'd8);
    tick(); tick();
    checks++; if (shadow_count !== 4'd3) $display("FAIL mid_pre got shadow=%0d want 3", shadow_count); else passed++;
    reset = 1'b1;
    tick();
    checks++; if (load !== 1'b0 || data_in !== 4'd2 || up_down !== 1'b1 || cmd_ready !== 1'b1 || shadow_count !== 4'd2 || done !== 1'b0 || cmd_err !== 1'b0)
      $display("FAIL mid_reset got load=%0b data_in=%0d ud=%0b ready=%0b shadow=%0d done=%0b err=%0b want 0/2/1/1/2/0/0",
               load, data_in, up_down, cmd_ready, shadow_count, done, cmd_err); else passed++;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (done !== 1'b0 || shadow_count !== 4'd2) $display("FAIL mid_after[%0d] got done=%0b shadow=%0d want 0/2", i, done, shadow_count); else passed++;
    end
    checks++; if (ctr !== 4'd2) $display("FAIL mid_counter got %0d want 2", ctr); else passed++;
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_steps = 8'd2; cmd_data = 4'd0;
    tick();
    checks++; if (cmd_ready !== 1'b0 || load !== 1'b1) $display("FAIL b2b_acc1 got ready=%0b load=%0b want 0/1", cmd_ready, load); else passed++;
    tick();
    checks++; if (shadow_count !== 4'd3 || cmd_ready !== 1'b0) $display("FAIL b2b_busy got shadow=%0d ready=%0b want 3/0", shadow_count, cmd_ready); else passed++;
    tick();
    checks++; if (shadow_count !== 4'd4 || done !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL b2b_done got shadow=%0d done=%0b ready=%0b want 4/1/1", shadow_count, done, cmd_ready); else passed++;
    tick();
    checks++; if (cmd_ready !== 1'b0 || load !== 1'b1 || shadow_count !== 4'd4 || done !== 1'b0)
      $display("FAIL b2b_acc2 got ready=%0b load=%0b shadow=%0d done=%0b want 0/1/4/0", cmd_ready, load, shadow_count, done); else passed++;
    cmd_valid = 1'b0;
    tick();
    checks++; if (shadow_count !== 4'd5) $display("FAIL b2b_step got %0d want 5", shadow_count); else passed++;
    tick();
    checks++; if (shadow_count !== 4'd6 || done !== 1'b1 || ctr !== 4'd6)
      $display("FAIL b2b_end got shadow=%0d done=%0b ctr=%0d want 6/1/6", shadow_count, done, ctr); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_up_wrap();
    test_down_wrap();
    test_bad_load();
    test_hold_and_zero();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/count_cmd_sequencer.md
# count_cmd_sequencer

Upstream command sequencer for the 4-bit loadable up-down counter (range 2..10). It accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and drives the counter's active-low `load`, `data_in` and `up_down` inputs cycle by cycle. It keeps a shadow copy of the expected counter value so the counter holds still whenever no command is executing. It also exposes that shadow value to the scoreboard.

## Interface

Parameters:
- `WIDTH`, 4: counter data width.
- `MIN_VAL`, 2: lowest counter value.
- `MAX_VAL`, 10: highest counter value.
- `STEP_W`, 8: width of the step-count field.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  2: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_data`  in  WIDTH: load value. Used only by LOAD.
- `cmd_steps`  in  STEP_W: number of cycles for UP/DOWN/HOLD. A value of 0 is treated as 1.
- `load`  out  1: active-low load to the counter.
- `data_in`  out  WIDTH: load data to the counter.
- `up_down`  out  1: 1 = count up, 0 = count down.
- `shadow_count`  out  WIDTH: value the counter holds after the current edge.
- `done`  out  1: one-cycle pulse when a command completes.
- `cmd_err`  out  1: one-cycle pulse when a command is rejected.

## Operation

- **States:** IDLE, LOAD, RUN, HOLD.
- **Handshake:** a command is accepted when `cmd_valid & cmd_ready` is true at a rising edge.
  - `cmd_ready` is 1 only in IDLE.
  - While busy, `cmd_valid` is ignored and the master must hold the command.
- **IDLE:** drives `load`=0 and `data_in`=`shadow_count`, so the counter reloads its own value and stays constant.
- **LOAD:**
  - If `cmd_data` is in [MIN_VAL, MAX_VAL]: one cycle with `load`=0 and `data_in`=`cmd_data`. The shadow takes `cmd_data`.
  - If `cmd_data` is out of range: the command is dropped. `cmd_err` pulses, state stays IDLE, the shadow is unchanged, and no `done` pulse is issued.
- **RUN (UP/DOWN):** N=max(`cmd_steps`,1) cycles with `load`=1 and `up_down`=op==UP. The shadow steps once per cycle with wrap-around:
  - MAX_VAL+1 wraps to MIN_VAL.
  - MIN_VAL-1 wraps to MAX_VAL.
- **HOLD:** N cycles with `load`=0 and `data_in`=`shadow_count`. The shadow is unchanged.
- **Completion:** after the last command cycle the FSM returns to IDLE, and `done` pulses.
- `up_down` keeps its last driven value in IDLE and HOLD.
- **Arithmetic:** wrap is computed at width WIDTH+1 to avoid overflow. The step counter is STEP_W bits and counts down to 1.

## Timing

- All outputs are registered.
- Reset values:
  - `load`=0, `data_in`=MIN_VAL, `up_down`=1
  - `cmd_ready`=1, `shadow_count`=MIN_VAL
  - `done`=0, `cmd_err`=0
  - state = IDLE
- The counter is therefore reloaded to MIN_VAL on the first edge after reset.
- Command accepted at edge k:
  - Command control values appear on `load`/`data_in`/`up_down` from edge k.
  - The counter samples them at edges k+1 .. k+N (LOAD: N=1).
  - `shadow_count` updates at the same edges as the counter.
- At edge k+N:
  - State is IDLE, `cmd_ready`=1 and `done`=1 for that one cycle.
  - `data_in`=final shadow value and `load`=0.
- A new command may be accepted at edge k+N+1 at the earliest.
- **Latency:** LOAD = 1 cycle; UP/DOWN/HOLD = N cycles; back-to-back throughput is one command per N+1 cycles.
- **Rejected LOAD accepted at edge k:** `cmd_err`=1 during the cycle after edge k. `cmd_ready` stays 1 and outputs are unchanged.
- **Reset mid-command:** reset has priority over everything. The command is aborted with no `done` pulse, and all outputs take their reset values at that edge.
- `cmd_valid` asserted on the same edge that reset is high is not accepted.

## Test plan

- **Reset:** assert `reset` for 2 cycles -> `load`=0, `data_in`=2, `up_down`=1, `cmd_ready`=1, `shadow_count`=2, `done`=`cmd_err`=0. The counter output reads 2 one edge later.
- **LOAD then UP with wrap:** LOAD 5, then UP steps=7 -> `shadow_count` sequence 6,7,8,9,10,2,3. `done` pulses after the 7th cycle. The counter output matches the shadow every cycle and stays at 3 in IDLE.
- **DOWN with wrap:** from 3, DOWN steps=3 -> 2,10,9. `up_down`=0 for exactly 3 cycles with `load`=1.
- **Out-of-range LOAD:** LOAD 11 (and LOAD 1) -> `cmd_err` pulses once, there is no `done`, the shadow and counter are unchanged, and `cmd_ready` stays 1.
- **HOLD and zero steps:** HOLD steps=4 -> `load`=0 for 4 cycles and the counter is constant. UP steps=0 -> exactly 1 increment, then `done`.
- **Reset mid-operation and busy handshake:**
  - Assert reset during cycle 3 of UP steps=8 -> no `done`, and all outputs take reset values at that edge.
  - A `cmd_valid` held while busy is accepted only on the edge after `done`.
